// File: rtl/uart_line_echo.sv
// uart_line_echo: serial echo engine wrapped around a small uart (rx/tx FIFOs,
// 16x oversampling baud generator). Two echo modes, chosen at line boundaries:
//   char mode (line_mode=0): every received byte is written straight back out.
//   line mode (line_mode=1): bytes collect in a line buffer. The whole line is
//   echoed when LINE_TERM arrives or the buffer fills. A fill without a
//   terminator sets the sticky overflow flag.
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   rx / tx          serial in / out (8N1, tx idles high)
//   dvsr             baud divisor: one oversample tick every dvsr+1 clocks
//   line_mode        echo mode, sampled only while idle with an empty line
//   ovf_clr          clears overflow; a simultaneous set wins
//   busy             engine not idle, or a line is partially buffered
//   line_len         bytes currently held in the line buffer
//   overflow         sticky: a line hit DEPTH bytes without LINE_TERM
// Optional build macro: UART_ECHO_UPCASE_EN. When defined, lower-case ASCII
// is upper-cased as it is captured, in both modes.
// Handshake: r_data is valid whenever rx_empty is low (first-word fall-through).
// rd_uart and wr_uart are registered single-cycle pulses. A pulse transfers one
// byte in the cycle it is high. A push is ignored while the FIFO is full.
// All FSM state is held in the *_state_q / state_q registers.

module uart_fifo #(
  parameter int AW = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] w_data,
  output logic       empty,
  output logic       full,
  output logic [7:0] r_data
);
  localparam int N = 1 << AW;
  logic [7:0]    mem_q [N];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_en, rd_en;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == (AW+1)'(N));
  assign wr_en  = wr & ~full;
  assign rd_en  = rd & ~empty;
  assign r_data = mem_q[rptr_q];

  always_comb begin
    wptr_d = wr_en ? wptr_q + 1'b1 : wptr_q;
    rptr_d = rd_en ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q;
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= w_data;
  end
endmodule

module uart #(
  parameter int ADDR_WIDTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_uart,
  input  logic        wr_uart,
  input  logic        rx,
  input  logic [7:0]  w_data,
  input  logic [10:0] dvsr,
  output logic        tx_full,
  output logic        rx_empty,
  output logic        tx,
  output logic [7:0]  r_data
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_e;

  logic [10:0] cnt_q, cnt_d;
  logic        tick;
  logic [1:0]  rx_sync_q, rx_sync_d;
  logic        rx_s;
  ser_state_e  rx_state_q, rx_state_d, tx_state_q, tx_state_d;
  logic [3:0]  rx_s_q, rx_s_d, tx_s_q, tx_s_d;
  logic [2:0]  rx_n_q, rx_n_d, tx_n_q, tx_n_d;
  logic [7:0]  rx_b_q, rx_b_d, tx_b_q, tx_b_d;
  logic        tx_q, tx_d;
  logic        rx_done, tx_done, tx_empty;
  logic [7:0]  tx_head;

  assign tick = (cnt_q == dvsr);
  assign rx_s = rx_sync_q[1];
  assign tx   = tx_q;

  always_comb begin
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    rx_sync_d  = {rx_sync_q[0], rx};
    rx_state_d = rx_state_q;
    rx_s_d     = rx_s_q;
    rx_n_d     = rx_n_q;
    rx_b_d     = rx_b_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      S_IDLE: if (!rx_s) begin
        rx_state_d = S_START;
        rx_s_d     = '0;
      end
      // Half a bit into the start bit; a high line here was a glitch.
      S_START: if (tick) begin
        if (rx_s_q == 4'd7) begin
          rx_state_d = rx_s ? S_IDLE : S_DATA;
          rx_s_d     = '0;
          rx_n_d     = '0;
        end else rx_s_d = rx_s_q + 1'b1;
      end
      S_DATA: if (tick) begin
        if (rx_s_q == 4'd15) begin
          rx_s_d = '0;
          rx_b_d = {rx_s, rx_b_q[7:1]};
          if (rx_n_q == 3'd7) rx_state_d = S_STOP;
          else rx_n_d = rx_n_q + 1'b1;
        end else rx_s_d = rx_s_q + 1'b1;
      end
      default: if (tick) begin
        if (rx_s_q == 4'd15) begin
          rx_state_d = S_IDLE;
          rx_done    = 1'b1;
        end else rx_s_d = rx_s_q + 1'b1;
      end
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_b_d     = tx_b_q;
    tx_d       = 1'b1;
    tx_done    = 1'b0;
    case (tx_state_q)
      // The FIFO head is copied here and popped only when the frame ends.
      S_IDLE: if (!tx_empty) begin
        tx_state_d = S_START;
        tx_s_d     = '0;
        tx_b_d     = tx_head;
      end
      S_START: begin
        tx_d = 1'b0;
        if (tick) begin
          if (tx_s_q == 4'd15) begin
            tx_state_d = S_DATA;
            tx_s_d     = '0;
            tx_n_d     = '0;
          end else tx_s_d = tx_s_q + 1'b1;
        end
      end
      S_DATA: begin
        tx_d = tx_b_q[0];
        if (tick) begin
          if (tx_s_q == 4'd15) begin
            tx_s_d = '0;
            tx_b_d = tx_b_q >> 1;
            if (tx_n_q == 3'd7) tx_state_d = S_STOP;
            else tx_n_d = tx_n_q + 1'b1;
          end else tx_s_d = tx_s_q + 1'b1;
        end
      end
      default: if (tick) begin
        if (tx_s_q == 4'd15) begin
          tx_state_d = S_IDLE;
          tx_done    = 1'b1;
        end else tx_s_d = tx_s_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      rx_sync_q  <= 2'b11;
      rx_state_q <= S_IDLE;
      rx_s_q     <= '0;
      rx_n_q     <= '0;
      rx_b_q     <= '0;
      tx_state_q <= S_IDLE;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_s_q     <= rx_s_d;
      rx_n_q     <= rx_n_d;
      rx_b_q     <= rx_b_d;
      tx_state_q <= tx_state_d;
      tx_s_q     <= tx_s_d;
      tx_n_q     <= tx_n_d;
      tx_b_q     <= tx_b_d;
      tx_q       <= tx_d;
    end
  end

  uart_fifo #(.AW(ADDR_WIDTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .rd(rd_uart), .wr(rx_done), .w_data(rx_b_q),
    .empty(rx_empty), .full(), .r_data(r_data)
  );

  uart_fifo #(.AW(ADDR_WIDTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .rd(tx_done), .wr(wr_uart), .w_data(w_data),
    .empty(tx_empty), .full(tx_full), .r_data(tx_head)
  );
endmodule

module uart_line_echo #(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] LINE_TERM = 8'h0D,
  parameter int         FIFO_AW   = 2,
  localparam int        LEN_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic             tx,
  input  logic [10:0]      dvsr,
  input  logic             line_mode,
  input  logic             ovf_clr,
  output logic             busy,
  output logic [LEN_W-1:0] line_len,
  output logic             overflow
);
  localparam int               AW      = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic [2:0] {IDLE, STORE, PUSH, GAP_C, DRAIN} state_e;

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [7:0]       byte_q, byte_d, w_data_q, w_data_d;
  logic             rd_uart_q, rd_uart_d, wr_uart_q, wr_uart_d;
  logic [LEN_W-1:0] line_len_q, line_len_d, rd_ptr_q, rd_ptr_d, len_inc;
  logic             overflow_q, overflow_d;
  logic [7:0]       line_buf_q [DEPTH];
  logic             buf_we, ovf_set;
  logic             tx_full, rx_empty;
  logic [7:0]       r_data, cap_byte;

`ifdef UART_ECHO_UPCASE_EN
  assign cap_byte = (r_data >= 8'h61 && r_data <= 8'h7A) ? r_data - 8'h20 : r_data;
`else
  assign cap_byte = r_data;
`endif

  assign len_inc  = line_len_q + 1'b1;
  assign busy     = (state_q != IDLE) || (line_len_q != '0);
  assign line_len = line_len_q;
  assign overflow = overflow_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    byte_d     = byte_q;
    w_data_d   = w_data_q;
    line_len_d = line_len_q;
    rd_ptr_d   = rd_ptr_q;
    rd_uart_d  = 1'b0;
    wr_uart_d  = 1'b0;
    buf_we     = 1'b0;
    ovf_set    = 1'b0;
    case (state_q)
      IDLE: begin
        // Mode changes only between lines; a half-built line keeps its mode.
        if (line_len_q == '0) mode_d = line_mode;
        if (!rx_empty) begin
          byte_d    = cap_byte;
          rd_uart_d = 1'b1;
          state_d   = STORE;
        end
      end
      STORE: begin
        if (!mode_q) state_d = PUSH;
        else begin
          buf_we     = 1'b1;
          line_len_d = len_inc;
          if (byte_q == LINE_TERM || len_inc == DEPTH_L) begin
            rd_ptr_d = '0;
            state_d  = DRAIN;
            ovf_set  = (byte_q != LINE_TERM);
          end else state_d = IDLE;
        end
      end
      PUSH: if (!tx_full) begin
        w_data_d  = byte_q;
        wr_uart_d = 1'b1;
        state_d   = GAP_C;
      end
      GAP_C: state_d = IDLE;
      DRAIN: begin
        // tx_full lags a push by one cycle, so never push in back-to-back cycles.
        if (!tx_full && !wr_uart_q) begin
          w_data_d  = line_buf_q[rd_ptr_q[AW-1:0]];
          wr_uart_d = 1'b1;
          rd_ptr_d  = rd_ptr_q + 1'b1;
          if (rd_ptr_q == line_len_q - 1'b1) begin
            line_len_d = '0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    overflow_d = (overflow_q & ~ovf_clr) | ovf_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      byte_q     <= '0;
      w_data_q   <= '0;
      rd_uart_q  <= 1'b0;
      wr_uart_q  <= 1'b0;
      line_len_q <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      byte_q     <= byte_d;
      w_data_q   <= w_data_d;
      rd_uart_q  <= rd_uart_d;
      wr_uart_q  <= wr_uart_d;
      line_len_q <= line_len_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) line_buf_q[line_len_q[AW-1:0]] <= byte_q;
  end

  uart #(.ADDR_WIDTH(FIFO_AW)) u_uart (
    .clk(clk), .reset(reset), .rd_uart(rd_uart_q), .wr_uart(wr_uart_q), .rx(rx),
    .w_data(w_data_q), .dvsr(dvsr), .tx_full(tx_full), .rx_empty(rx_empty),
    .tx(tx), .r_data(r_data)
  );
endmodule

// File: tb/tb_uart_line_echo.sv
// Bench for uart_line_echo with DEPTH=4 and dvsr=4, which gives 80 clocks per bit.
// Serial frames are driven on rx. A monitor decodes the frames on tx into got_q.
// A queue-based line model fills exp_q with the bytes that should come back.
module tb_uart_line_echo;
  localparam int         DEPTH = 4;
  localparam logic [7:0] TERM  = 8'h0D;
  localparam int         LEN_W = $clog2(DEPTH) + 1;
  localparam int         BIT   = 80;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             rx = 1'b1;
  logic             tx;
  logic [10:0]      dvsr = 11'd4;
  logic             line_mode = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             busy;
  logic [LEN_W-1:0] line_len;
  logic             overflow;

  int         checks = 0;
  int         errors = 0;
  int         epoch = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] line_q[$];
  logic       model_mode = 1'b0;
  logic       model_ovf = 1'b0;

  uart_line_echo #(.DEPTH(DEPTH), .LINE_TERM(TERM), .FIFO_AW(2)) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .dvsr(dvsr),
    .line_mode(line_mode), .ovf_clr(ovf_clr), .busy(busy),
    .line_len(line_len), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // tx monitor. A frame cut short by a reset belongs to an old epoch and is dropped.
  initial begin
    logic [7:0] b;
    logic       ok;
    int         ep;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        ep = epoch;
        ok = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = tx;
        end
        repeat (BIT) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
        if (ep == epoch) got_q.push_back(ok ? b : 8'hxx);
      end
    end
  end

  function automatic logic [7:0] conv(input logic [7:0] raw);
`ifdef UART_ECHO_UPCASE_EN
    if (raw >= 8'h61 && raw <= 8'h7A) return raw - 8'h20;
`endif
    return raw;
  endfunction

  // Line model: the mode is latched when a line starts. Char mode echoes each
  // byte. Line mode emits the whole line on the terminator or when it is full.
  task automatic model_byte(input logic [7:0] raw);
    logic [7:0] b;
    b = conv(raw);
    if (line_q.size() == 0) model_mode = line_mode;
    if (!model_mode) exp_q.push_back(b);
    else begin
      line_q.push_back(b);
      if (b == TERM || line_q.size() == DEPTH) begin
        if (b != TERM) model_ovf = 1'b1;
        while (line_q.size() > 0) exp_q.push_back(line_q.pop_front());
      end
    end
  endtask

  task automatic send_raw(input logic [7:0] b);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic wait_len(input logic [LEN_W-1:0] want);
    int k = 0;
    while (line_len !== want && k < 6000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (got_q.size() < n && k < 4000 + 1000 * n) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (line_len !== '0) begin errors++; $display("FAIL reset_len: got %0d expected 0", line_len); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_char();
    logic [7:0] g, e;
    line_mode = 1'b0;
    send_raw(8'h41); model_byte(8'h41);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL char_busy: got %b expected 0", busy); end
    checks++; if (line_len !== '0) begin errors++; $display("FAIL char_len: got %0d expected 0", line_len); end
    wait_tx(exp_q.size());
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL char_echo[%0d]: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_line();
    logic [7:0] g, e;
    line_mode = 1'b1;
    send_raw(8'h61); model_byte(8'h61); wait_len(1);
    checks++; if (line_len !== 1) begin errors++; $display("FAIL line_len1: got %0d expected 1", line_len); end
    send_raw(8'h62); model_byte(8'h62); wait_len(2);
    checks++; if (line_len !== 2) begin errors++; $display("FAIL line_len2: got %0d expected 2", line_len); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL line_held: got %0d bytes expected 0", got_q.size()); end
    send_raw(TERM); model_byte(TERM); wait_len(0);
    checks++; if (line_len !== 0) begin errors++; $display("FAIL line_len0: got %0d expected 0", line_len); end
    wait_tx(exp_q.size());
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL line_echo[%0d]: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] g, e;
    line_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_raw(8'h31 + 8'(i)); model_byte(8'h31 + 8'(i)); wait_len(LEN_W'(i + 1));
      checks++; if (line_len !== LEN_W'(i + 1)) begin errors++; $display("FAIL ovf_len[%0d]: got %0d expected %0d", i, line_len, i + 1); end
    end
    send_raw(8'h34); model_byte(8'h34); wait_len(0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    send_raw(8'h35); model_byte(8'h35); wait_len(1);
    checks++; if (line_len !== 1) begin errors++; $display("FAIL ovf_newline: got %0d expected 1", line_len); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0; @(negedge clk); model_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
    wait_tx(exp_q.size());
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL ovf_echo[%0d]: got %h expected %h", i, g, e); end
    end
  endtask

  // Continues the line left holding 8'h35: the fourth byte is the terminator.
  task automatic test_full_term();
    logic [7:0] g, e;
    send_raw(8'h36); model_byte(8'h36);
    send_raw(8'h37); model_byte(8'h37); wait_len(3);
    checks++; if (line_len !== 3) begin errors++; $display("FAIL full_term_len: got %0d expected 3", line_len); end
    send_raw(TERM); model_byte(TERM); wait_len(0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_term_ovf: got %b expected 0", overflow); end
    wait_tx(exp_q.size());
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL full_term_echo[%0d]: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_toggle();
    logic [7:0] g, e;
    line_mode = 1'b1;
    send_raw(8'h41); model_byte(8'h41);
    send_raw(8'h42); model_byte(8'h42); wait_len(2);
    line_mode = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (line_len !== 2) begin errors++; $display("FAIL toggle_held: got %0d expected 2", line_len); end
    send_raw(TERM); model_byte(TERM); wait_len(0);
    send_raw(8'h7A); model_byte(8'h7A);
    wait_tx(exp_q.size());
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL toggle_busy: got %b expected 0", busy); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL toggle_echo[%0d]: got %h expected %h", i, g, e); end
    end
  endtask

  // ovf_clr is held high through the overflowing byte and dropped the cycle
  // after the line fills, so the set and the clear land in the same cycle.
  task automatic test_ovf_race();
    logic [7:0] g, e;
    int k;
    line_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_raw(8'h41 + 8'(i)); model_byte(8'h41 + 8'(i));
    end
    wait_len(3);
    ovf_clr = 1'b1;
    fork send_raw(8'h44); join_none
    k = 0;
    while (line_len !== LEN_W'(DEPTH) && k < 3000) begin @(negedge clk); k++; end
    ovf_clr = 1'b0;
    wait fork;
    model_byte(8'h44);
    repeat (2) @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_race: got %b expected 1", overflow); end
    wait_tx(exp_q.size());
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL race_echo[%0d]: got %h expected %h", i, g, e); end
    end
  endtask

  // Enters with overflow still set from the previous test.
  task automatic test_reset_mid();
    logic [7:0] g, e;
    int k;
    line_mode = 1'b1;
    send_raw(8'h78); model_byte(8'h78);
    send_raw(8'h79); model_byte(8'h79); wait_len(2);
    fork send_raw(TERM); join_none
    k = 0;
    while (line_len !== 3 && k < 3000) begin @(negedge clk); k++; end
    checks++; if (line_len !== 3) begin errors++; $display("FAIL mid_drain: got %0d expected 3", line_len); end
    reset = 1'b1;
    epoch++;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_tx: got %b expected 1", tx); end
    checks++; if (line_len !== '0) begin errors++; $display("FAIL mid_len: got %0d expected 0", line_len); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b expected 0", overflow); end
    line_q.delete(); exp_q.delete(); got_q.delete();
    model_mode = 1'b0; model_ovf = 1'b0;
    reset = 1'b0;
    wait fork;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_after_busy: got %b expected 0", busy); end
    line_mode = 1'b0;
    send_raw(8'h55); model_byte(8'h55);
    wait_tx(exp_q.size());
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL mid_echo[%0d]: got %h expected %h", i, g, e); end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_extra: got %0d bytes expected 0", got_q.size()); end
  endtask

  task automatic test_random();
    logic [7:0] g, e, b;
    ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0; @(negedge clk);
    model_ovf = 1'b0;
    for (int i = 0; i < 14; i++) begin
      line_mode = 1'($urandom_range(0, 1));
      b = ($urandom_range(0, 3) == 0) ? TERM : 8'($urandom_range(0, 255));
      send_raw(b); model_byte(b); wait_len(LEN_W'(line_q.size()));
      checks++;
      if (line_len !== LEN_W'(line_q.size())) begin
        errors++; $display("FAIL rand_len[%0d]: got %0d expected %0d", i, line_len, line_q.size());
      end
    end
    send_raw(TERM); model_byte(TERM); wait_len(0);
    wait_tx(exp_q.size());
    checks++; if (overflow !== model_ovf) begin errors++; $display("FAIL rand_ovf: got %b expected %b", overflow, model_ovf); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL rand_echo[%0d]: got %h expected %h", i, g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_char();
    test_line();
    test_overflow();
    test_full_term();
    test_toggle();
    test_ovf_race();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
